// File: rtl/operand_feeder.sv
// operand_feeder: stores one operand tile as column vectors and streams it
// one column per cycle toward the skew buffer. ARRAY_SIZE-1 zero flush
// cycles follow the stream so the deepest skew row drains. The block owns
// the skew buffer enable, so one stall freezes the whole feed path.
module operand_feeder #(
    parameter int ARRAY_SIZE = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW = $clog2(DEPTH + 1),
    localparam int VW = ARRAY_SIZE * DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic signed [VW-1:0] wr_data,
    input  logic                 start,
    input  logic [LW-1:0]        len,
    input  logic                 stall,
    output logic signed [VW-1:0] vec_out,
    output logic                 vec_valid,
    output logic                 skew_en,
    output logic                 busy,
    output logic                 done
);

    localparam int            FW          = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam logic [LW-1:0] DEPTH_LEN   = LW'(DEPTH);
    localparam logic [AW:0]   DEPTH_ADDR  = (AW + 1)'(DEPTH);
    localparam logic [FW-1:0] FLUSH_LAST  = FW'((ARRAY_SIZE > 1) ? ARRAY_SIZE - 2 : 0);
    localparam logic          SINGLE_ROW  = (ARRAY_SIZE == 1) ? 1'b1 : 1'b0;
    localparam logic [LW-1:0] LEN_ONE     = LW'(1);
    localparam logic [FW-1:0] FCNT_ONE    = FW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [VW-1:0] vec_out_q, vec_out_d;
    logic          vec_valid_q, vec_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [VW-1:0] mem_q [DEPTH];
    logic [VW-1:0] mem_d [DEPTH];

    logic          start_ok_s;
    logic          wr_ok_s;
    logic [LW-1:0] len_clamp_s;
    logic [LW-1:0] last_cnt_s;
    logic [AW-1:0] rd_addr_s;

    // Decode accepted start, clamped length, legal write and next read index.
    always_comb begin
        start_ok_s  = (state_q == ST_IDLE) && start && (len != {LW{1'b0}});
        len_clamp_s = (len > DEPTH_LEN) ? DEPTH_LEN : len;
        wr_ok_s     = (state_q == ST_IDLE) && wr_en &&
                      ({1'b0, wr_addr} < DEPTH_ADDR) && !start_ok_s;
        last_cnt_s  = len_q - LEN_ONE;
        rd_addr_s   = AW'(cnt_q + LEN_ONE);
    end

    // Next-state logic for the feed FSM, its outputs and the tile storage.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        fcnt_d      = fcnt_q;
        vec_out_d   = vec_out_q;
        vec_valid_d = vec_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mem_d       = mem_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d     = ST_STREAM;
                    cnt_d       = {LW{1'b0}};
                    len_d       = len_clamp_s;
                    fcnt_d      = {FW{1'b0}};
                    vec_out_d   = mem_q[{AW{1'b0}}];
                    vec_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end else begin
                    vec_out_d   = {VW{1'b0}};
                    vec_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    if (wr_ok_s) begin
                        mem_d[wr_addr] = wr_data;
                    end else begin
                        mem_d = mem_q;
                    end
                end
            end
            ST_STREAM: begin
                if (stall) begin
                    state_d = ST_STREAM;
                end else if (cnt_q == last_cnt_s) begin
                    cnt_d       = {LW{1'b0}};
                    vec_out_d   = {VW{1'b0}};
                    vec_valid_d = 1'b0;
                    fcnt_d      = {FW{1'b0}};
                    if (SINGLE_ROW) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end else begin
                    cnt_d     = cnt_q + LEN_ONE;
                    vec_out_d = mem_q[rd_addr_s];
                end
            end
            ST_FLUSH: begin
                if (stall) begin
                    state_d = ST_FLUSH;
                end else if (fcnt_q == FLUSH_LAST) begin
                    state_d = ST_IDLE;
                    fcnt_d  = {FW{1'b0}};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    fcnt_d = fcnt_q + FCNT_ONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                vec_out_d   = {VW{1'b0}};
                vec_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State, output and storage registers; reset aborts and clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {LW{1'b0}};
            len_q       <= {LW{1'b0}};
            fcnt_q      <= {FW{1'b0}};
            vec_out_q   <= {VW{1'b0}};
            vec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {VW{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            fcnt_q      <= fcnt_d;
            vec_out_q   <= vec_out_d;
            vec_valid_q <= vec_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_q       <= mem_d;
        end
    end

    assign vec_out   = vec_out_q;
    assign vec_valid = vec_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign skew_en   = busy_q & ~stall;

endmodule
